sum_of_products_mac: RTL and testbench
======================================

Name: sum_of_products_mac

Overview:
- Parametrised N-lane sum-of-products engine with an optional running accumulator, built for DSP-block mapping tests.
- Each valid cycle, NUM_MULT independent lanes compute a[i]*b[i]; the products are summed and either loaded into or added to an accumulator.
- Fully pipelined with valid tracking, signed/unsigned mode, wrap or saturate on overflow, and a sticky overflow flag.
- Sits between sample sources and downstream filter/correlator logic.

Parameters:
- INPUT_WIDTH, 14, width of each a/b lane operand.
- NUM_MULT, 4, number of multiplier lanes (1..16).
- ACC_WIDTH, 32, accumulator and output width; must be >= 2*INPUT_WIDTH + clog2(NUM_MULT).
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands.
- SATURATE, 0, 0 = accumulator wraps on overflow, 1 = accumulator clamps to max/min.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- in_valid  in  1  qualifies a, b, acc_en, acc_clear this cycle.
- a  in  NUM_MULT*INPUT_WIDTH  packed lane operands; lane i = a[i*INPUT_WIDTH +: INPUT_WIDTH].
- b  in  NUM_MULT*INPUT_WIDTH  packed lane operands, same packing as a.
- acc_en  in  1  1 = add this sample's sum to the accumulator; 0 = load the sum.
- acc_clear  in  1  1 = start a fresh accumulation (acts as load, clears overflow); overrides acc_en.
- out_valid  out  1  y updated this cycle.
- y  out  ACC_WIDTH  accumulator value.
- overflow  out  1  sticky overflow/saturation indicator.

Behaviour:
- Reset (synchronous): out_valid=0, y=0, overflow=0, all internal stage valids=0. Asserting reset mid-operation discards every in-flight sample. The first sample accepted after reset deasserts is handled normally.
- Pipeline: 3 register stages; latency is exactly 3 cycles from in_valid to out_valid. The pipeline accepts one sample per cycle and has no backpressure.
  - S1: register NUM_MULT products, each 2*INPUT_WIDTH bits, signed or unsigned per SIGNED.
  - S2: register the adder-tree sum, width SUM_W = 2*INPUT_WIDTH + clog2(NUM_MULT). The sum is exact and cannot overflow.
  - S3: accumulator update, with y as the register output.
- acc_en and acc_clear travel alongside valid through S1/S2 and are evaluated at S3.
- Data registers load only when their stage valid is set. During bubbles, y holds its last value and out_valid=0.
- S3 operation for a valid sample:
  - acc_clear=1: y <= ext(sum); overflow <= 0.
  - acc_clear=0, acc_en=0: y <= ext(sum); overflow unchanged.
  - acc_clear=0, acc_en=1: y <= y + ext(sum).
- ext() zero-extends when SIGNED=0 and sign-extends when SIGNED=1.
- Overflow detection:
  - Unsigned: carry out of ACC_WIDTH.
  - Signed: both operands have the same sign and the result sign differs.
- On overflow:
  - SATURATE=0: y takes the wrapped value.
  - SATURATE=1: y takes the all-ones value (unsigned), or max positive / min negative by operand sign (signed).
  - In both modes, overflow is set to 1 and stays set until acc_clear or reset.
- Once saturated, further accumulation in the same direction holds the clamp; accumulation in the opposite direction proceeds from the clamped value.
- in_valid=0 with acc_clear=1 has no effect (the control is qualified by valid).
- Width legality (ACC_WIDTH >= SUM_W, 1 <= NUM_MULT <= 16) is checked at elaboration; a violation is a fatal elaboration error.

Decomposition:
- Shared package sop_pkg:
  - clog2 function.
  - Derived constants PROD_W = 2*INPUT_WIDTH and SUM_W.
  - Saturation limit helpers (max/min for a width and signedness).
- One sub-module, sop_adder_tree: parametrised balanced combinational reduction of NUM_MULT PROD_W-bit values to SUM_W bits, honouring SIGNED. The S2 register stays in the top module.
- Multipliers are inferred inline per lane, not as separate instances.

Test Plan:
- Defaults, every lane a=3, b=5, in_valid for 1 cycle, acc_en=0 -> exactly 3 cycles later out_valid=1 and y=60; out_valid=0 on surrounding cycles.
- Same stimulus back-to-back for 3 cycles; first acc_clear=1, then acc_en=1 -> y=60, 120, 180 on consecutive cycles. Insert a 2-cycle bubble -> y holds 180 with out_valid=0.
- SIGNED=1, lane0 a=-2, b=7, other lanes a=1, b=1 -> y = -14+3 = -11 (0xFFFFFFF5).
- SIGNED=0, ACC_WIDTH=SUM_W=30, all lanes a=b=16383, accumulate 2 samples:
  - SATURATE=0 -> y wraps to 2*1073610756 mod 2^30, overflow=1.
  - SATURATE=1 -> y=2^30-1, overflow=1.
  - A following acc_clear sample -> overflow=0.
- Reset asserted while 2 samples are in flight -> no out_valid for those samples, y=0, overflow=0. A sample issued the cycle after reset deasserts appears 3 cycles later.
- NUM_MULT=1 and NUM_MULT=7: random operands against a reference model with random acc_en/acc_clear/in_valid patterns -> bit-exact y, out_valid, overflow every cycle.

Source files
------------

// File: rtl/sop_pkg.sv
// Shared helpers for the sum-of-products MAC: width arithmetic and saturation limits.
package sop_pkg;

  // Widest accumulator the saturation helpers can describe.
  localparam int unsigned SopMaxW = 128;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned prod_w(input int unsigned iw);
    return 2 * iw;
  endfunction

  // Exact width of a sum of nm products of two iw-bit operands.
  function automatic int unsigned sum_w(input int unsigned iw, input int unsigned nm);
    return 2 * iw + clog2(nm);
  endfunction

  // Largest representable value of a w-bit number, right-aligned in SopMaxW bits.
  function automatic logic [SopMaxW-1:0] sat_max(input int unsigned w, input bit is_signed);
    logic [SopMaxW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SopMaxW; i++) begin
      if (i < w - 32'(is_signed)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest representable value of a w-bit number, right-aligned in SopMaxW bits.
  function automatic logic [SopMaxW-1:0] sat_min(input int unsigned w, input bit is_signed);
    logic [SopMaxW-1:0] r;
    r = '0;
    if (is_signed) r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sop_adder_tree.sv
// Balanced combinational reduction of NUM_MULT products into one exact SUM_W-bit sum.
// Each product is extended to SUM_W first, so modulo-2^SUM_W addition is exact.
module sop_adder_tree #(
  parameter int unsigned NUM_MULT = 4,
  parameter int unsigned PROD_W   = 28,
  parameter int unsigned SUM_W    = 30,
  parameter int unsigned SIGNED   = 0
) (
  input  logic [NUM_MULT*PROD_W-1:0] prods,
  output logic [SUM_W-1:0]           sum
);

  if (NUM_MULT == 1) begin : g_leaf
    if (SIGNED != 0) begin : g_sext
      assign sum = SUM_W'($signed(prods));
    end else begin : g_zext
      assign sum = SUM_W'(prods);
    end
  end else begin : g_split
    localparam int unsigned NumLo = NUM_MULT / 2;
    localparam int unsigned NumHi = NUM_MULT - NumLo;

    logic [SUM_W-1:0] sum_lo;
    logic [SUM_W-1:0] sum_hi;

    sop_adder_tree #(
      .NUM_MULT(NumLo),
      .PROD_W  (PROD_W),
      .SUM_W   (SUM_W),
      .SIGNED  (SIGNED)
    ) u_lo (
      .prods(prods[NumLo*PROD_W-1:0]),
      .sum  (sum_lo)
    );

    sop_adder_tree #(
      .NUM_MULT(NumHi),
      .PROD_W  (PROD_W),
      .SUM_W   (SUM_W),
      .SIGNED  (SIGNED)
    ) u_hi (
      .prods(prods[NUM_MULT*PROD_W-1:NumLo*PROD_W]),
      .sum  (sum_hi)
    );

    assign sum = sum_lo + sum_hi;
  end

endmodule

// File: rtl/sum_of_products_mac.sv
// Three-stage N-lane sum-of-products with load/accumulate, wrap or saturate, sticky overflow.
module sum_of_products_mac
  import sop_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 14,
  parameter int unsigned NUM_MULT    = 4,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned SIGNED      = 0,
  parameter int unsigned SATURATE    = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [NUM_MULT*INPUT_WIDTH-1:0] a,
  input  logic [NUM_MULT*INPUT_WIDTH-1:0] b,
  input  logic                            acc_en,
  input  logic                            acc_clear,
  output logic                            out_valid,
  output logic [ACC_WIDTH-1:0]            y,
  output logic                            overflow
);

  localparam int unsigned PROD_W = prod_w(INPUT_WIDTH);
  localparam int unsigned SUM_W  = sum_w(INPUT_WIDTH, NUM_MULT);

  if (NUM_MULT < 1 || NUM_MULT > 16 || ACC_WIDTH < SUM_W || ACC_WIDTH > SopMaxW)
  begin : g_bad_cfg
    $fatal(1, "sum_of_products_mac: illegal NUM_MULT or ACC_WIDTH");
  end

  localparam logic [SopMaxW-1:0]   AccMaxFull = sat_max(ACC_WIDTH, SIGNED != 0);
  localparam logic [SopMaxW-1:0]   AccMinFull = sat_min(ACC_WIDTH, SIGNED != 0);
  localparam logic [ACC_WIDTH-1:0] AccMax     = AccMaxFull[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] AccMin     = AccMinFull[ACC_WIDTH-1:0];

  logic [NUM_MULT-1:0][PROD_W-1:0] prod_d, prod_q;
  logic                            v1_q, en1_q, clr1_q;
  logic [SUM_W-1:0]                tree_sum, sum_q;
  logic                            v2_q, en2_q, clr2_q;
  logic [ACC_WIDTH-1:0]            sum_ext, add_raw, y_d, y_q;
  logic                            add_carry, add_ovf, ovf_d, ovf_q, out_valid_q;

  // Per-lane multipliers; operands widened to PROD_W with the chosen signedness.
  always_comb begin
    for (int i = 0; i < NUM_MULT; i++) begin
      if (SIGNED != 0) begin
        prod_d[i] = PROD_W'($signed(a[i*INPUT_WIDTH +: INPUT_WIDTH]))
                  * PROD_W'($signed(b[i*INPUT_WIDTH +: INPUT_WIDTH]));
      end else begin
        prod_d[i] = PROD_W'(a[i*INPUT_WIDTH +: INPUT_WIDTH])
                  * PROD_W'(b[i*INPUT_WIDTH +: INPUT_WIDTH]);
      end
    end
  end

  // S1: product registers plus the controls that travel with the sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      en1_q  <= 1'b0;
      clr1_q <= 1'b0;
      prod_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        prod_q <= prod_d;
        en1_q  <= acc_en;
        clr1_q <= acc_clear;
      end
    end
  end

  sop_adder_tree #(
    .NUM_MULT(NUM_MULT),
    .PROD_W  (PROD_W),
    .SUM_W   (SUM_W),
    .SIGNED  (SIGNED)
  ) u_tree (
    .prods(prod_q),
    .sum  (tree_sum)
  );

  // S2: exact adder-tree sum register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q   <= 1'b0;
      en2_q  <= 1'b0;
      clr2_q <= 1'b0;
      sum_q  <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q  <= tree_sum;
        en2_q  <= en1_q;
        clr2_q <= clr1_q;
      end
    end
  end

  // S3 next state: load or accumulate, detect overflow, optionally clamp.
  always_comb begin
    if (SIGNED != 0) sum_ext = ACC_WIDTH'($signed(sum_q));
    else             sum_ext = ACC_WIDTH'(sum_q);
    {add_carry, add_raw} = {1'b0, y_q} + {1'b0, sum_ext};
    if (SIGNED != 0) begin
      add_ovf = (y_q[ACC_WIDTH-1] == sum_ext[ACC_WIDTH-1])
             && (add_raw[ACC_WIDTH-1] != y_q[ACC_WIDTH-1]);
    end else begin
      add_ovf = add_carry;
    end
    y_d   = y_q;
    ovf_d = ovf_q;
    if (v2_q) begin
      if (clr2_q) begin
        y_d   = sum_ext;
        ovf_d = 1'b0;
      end else if (!en2_q) begin
        y_d = sum_ext;
      end else begin
        y_d = add_raw;
        if (add_ovf) begin
          ovf_d = 1'b1;
          // Both operands share a sign on signed overflow, so y_q's sign picks the rail.
          if (SATURATE != 0) y_d = (SIGNED != 0 && y_q[ACC_WIDTH-1]) ? AccMin : AccMax;
        end
      end
    end
  end

  // S3: accumulator, sticky overflow and output valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_of_products_mac.sv
// Scoreboard bench: six MAC configurations driven side by side, each checked against an
// integer-arithmetic model of load/accumulate with wrap or saturate.
module tb_sum_of_products_mac;

  localparam int unsigned Iw = 14;
  localparam int unsigned NumDut = 6;
  // dut0 default, dut1 signed, dut2 30-bit wrap, dut3 30-bit sat, dut4 1 lane, dut5 7 lanes
  localparam logic [5:0][7:0] NM_P   = {8'd7, 8'd1, 8'd4, 8'd4, 8'd4, 8'd4};
  localparam logic [5:0][7:0] ACCW_P = {8'd31, 8'd28, 8'd30, 8'd30, 8'd32, 8'd32};
  localparam logic [5:0]      SGN_P  = 6'b100010;
  localparam logic [5:0]      SAT_P  = 6'b111000;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] y;
    logic        ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rst_q = 1'b0;
  logic [5:0]        iv = '0, en = '0, clr = '0, ov, of;
  logic [16*Iw-1:0]  a_bus [NumDut];
  logic [16*Iw-1:0]  b_bus [NumDut];
  logic [31:0]       yo    [NumDut];
  int unsigned       cyc = 0;
  int unsigned       checks = 0;
  int unsigned       errors = 0;

  exp_t        sb     [NumDut][$];
  longint      m_y    [NumDut];
  bit          m_ovf  [NumDut];
  logic [31:0] exp_y  [NumDut];
  logic        exp_o  [NumDut];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NumDut; k++) begin : g_dut
    localparam int unsigned Nm = int'(NM_P[k]);
    localparam int unsigned Aw = int'(ACCW_P[k]);
    logic [Aw-1:0] y_w;
    sum_of_products_mac #(
      .INPUT_WIDTH(Iw),
      .NUM_MULT   (Nm),
      .ACC_WIDTH  (Aw),
      .SIGNED     (int'(SGN_P[k])),
      .SATURATE   (int'(SAT_P[k]))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (iv[k]),
      .a        (a_bus[k][Nm*Iw-1:0]),
      .b        (b_bus[k][Nm*Iw-1:0]),
      .acc_en   (en[k]),
      .acc_clear(clr[k]),
      .out_valid(ov[k]),
      .y        (y_w),
      .overflow (of[k])
    );
    assign yo[k] = 32'(y_w);
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %h want %h", name, k, cyc, got, want);
    end
  endtask

  function automatic longint lane(input logic [Iw-1:0] x, input bit sg);
    if (sg) return longint'($signed(x));
    return longint'(x);
  endfunction

  // Model: exact integer sum, then load or add with range check against the accumulator width.
  task automatic issue(input int k, input bit v, input bit e, input bit c,
                       input logic [16*Iw-1:0] av, input logic [16*Iw-1:0] bv);
    longint s, t, hi, lo, md;
    int     nm, w;
    bit     sg, st;
    a_bus[k] = av;
    b_bus[k] = bv;
    iv[k]    = v;
    en[k]    = e;
    clr[k]   = c;
    if (!v) return;
    nm = int'(NM_P[k]);
    w  = int'(ACCW_P[k]);
    sg = SGN_P[k];
    st = SAT_P[k];
    md = longint'(1) << w;
    hi = sg ? (md / 2 - 1) : (md - 1);
    lo = sg ? -(md / 2) : 0;
    s  = 0;
    for (int i = 0; i < nm; i++) s += lane(av[i*Iw +: Iw], sg) * lane(bv[i*Iw +: Iw], sg);
    if (c) begin
      m_y[k]   = s;
      m_ovf[k] = 1'b0;
    end else if (!e) begin
      m_y[k] = s;
    end else begin
      t = m_y[k] + s;
      if (t > hi || t < lo) begin
        m_ovf[k] = 1'b1;
        if (st) begin
          t = (t > hi) ? hi : lo;
        end else begin
          t = ((t % md) + md) % md;
          if (sg && t > hi) t -= md;
        end
      end
      m_y[k] = t;
    end
    sb[k].push_back('{due: cyc + 3, y: 32'(m_y[k] & (md - 1)), ovf: m_ovf[k]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    iv  = '0;
    en  = '0;
    clr = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    iv    = '0;
    repeat (n) begin
      @(posedge clk);
      for (int k = 0; k < NumDut; k++) begin
        sb[k].delete();
        m_y[k]   = 0;
        m_ovf[k] = 1'b0;
        exp_y[k] = '0;
        exp_o[k] = 1'b0;
      end
      #1;
    end
    reset = 1'b0;
  endtask

  function automatic logic [16*Iw-1:0] fill(input logic [Iw-1:0] v);
    logic [16*Iw-1:0] r;
    for (int i = 0; i < 16; i++) r[i*Iw +: Iw] = v;
    return r;
  endfunction

  function automatic logic [16*Iw-1:0] rnd_lanes();
    logic [16*Iw-1:0] r;
    for (int i = 0; i < 16; i++) r[i*Iw +: Iw] = Iw'($urandom);
    return r;
  endfunction

  // Monitor: pop on out_valid, otherwise require y/overflow to hold.
  always @(negedge clk) begin
    for (int k = 0; k < NumDut; k++) begin
      if (rst_q) begin
        chk("reset_y", k, yo[k], 32'd0);
        chk("reset_flags", k, {30'd0, ov[k], of[k]}, 32'd0);
      end else if (ov[k]) begin
        if (sb[k].size() == 0) begin
          chk("unexpected_out_valid", k, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb[k].pop_front();
          chk("latency_cycle", k, cyc, e.due);
          chk("y", k, yo[k], e.y);
          chk("overflow", k, {31'd0, of[k]}, {31'd0, e.ovf});
          exp_y[k] = e.y;
          exp_o[k] = e.ovf;
        end
      end else begin
        chk("hold_y", k, yo[k], exp_y[k]);
        chk("hold_overflow", k, {31'd0, of[k]}, {31'd0, exp_o[k]});
        if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
          chk("missing_out_valid", k, 32'd0, 32'd1);
          void'(sb[k].pop_front());
        end
      end
    end
  end

  initial begin
    logic [16*Iw-1:0] sa, sbv, mx;
    for (int k = 0; k < NumDut; k++) begin
      a_bus[k] = '0;
      b_bus[k] = '0;
      m_y[k]   = 0;
      m_ovf[k] = 1'b0;
      exp_y[k] = '0;
      exp_o[k] = 1'b0;
    end
    do_reset(3);

    // Single load: 4 * 3 * 5 = 60.
    issue(0, 1, 0, 0, fill(14'd3), fill(14'd5));
    tick();
    repeat (4) tick();

    // Clear then accumulate twice: 60, 120, 180; bubbles hold 180.
    issue(0, 1, 0, 1, fill(14'd3), fill(14'd5)); tick();
    issue(0, 1, 1, 0, fill(14'd3), fill(14'd5)); tick();
    issue(0, 1, 1, 0, fill(14'd3), fill(14'd5)); tick();
    repeat (2) tick();
    // Unqualified clear must be ignored; next accumulate continues from 180.
    issue(0, 0, 0, 1, fill(14'd3), fill(14'd5)); tick();
    issue(0, 1, 1, 0, fill(14'd3), fill(14'd5)); tick();
    repeat (4) tick();

    // Signed: -2*7 + 3*1 = -11.
    sa  = fill(14'd1);
    sbv = fill(14'd1);
    sa[Iw-1:0]  = 14'h3FFE;
    sbv[Iw-1:0] = 14'd7;
    issue(1, 1, 0, 1, sa, sbv);
    tick();
    repeat (4) tick();

    // 30-bit unsigned accumulator at full-scale operands: wrap vs saturate, then clear.
    mx = fill(14'h3FFF);
    issue(2, 1, 0, 1, mx, mx); issue(3, 1, 0, 1, mx, mx); tick();
    issue(2, 1, 1, 0, mx, mx); issue(3, 1, 1, 0, mx, mx); tick();
    issue(2, 1, 1, 0, mx, mx); issue(3, 1, 1, 0, mx, mx); tick();
    issue(2, 1, 0, 1, mx, mx); issue(3, 1, 0, 1, mx, mx); tick();
    repeat (5) tick();

    // Reset with two samples in flight, then a sample right after release.
    issue(0, 1, 0, 1, fill(14'd3), fill(14'd5)); tick();
    issue(0, 1, 1, 0, fill(14'd3), fill(14'd5)); tick();
    do_reset(2);
    issue(0, 1, 0, 0, fill(14'd3), fill(14'd5)); tick();
    repeat (5) tick();

    // Random traffic on every configuration.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < NumDut; k++) begin
        issue(k, ($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 8) == 0,
              rnd_lanes(), rnd_lanes());
      end
      tick();
    end
    repeat (6) tick();

    for (int k = 0; k < NumDut; k++) chk("drained", k, 32'(sb[k].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
